// File: rtl/lsu_bus_ctrl.sv
// Load/store unit bus controller: drives one aligned bus access per
// legal request, extends load data and flags misaligned or timed-out accesses.
module lsu_bus_ctrl #(
  parameter int XLEN     = 32,
  parameter int WAIT_MAX = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read_i,
  input  logic              mem_write_i,
  input  logic [2:0]        funct3,
  input  logic [XLEN-1:0]   addr_i,
  input  logic [XLEN-1:0]   store_data_i,
  input  logic [XLEN-1:0]   data_bus_i,
  input  logic              data_good,
  output logic              data_read,
  output logic              data_write,
  output logic [XLEN-1:0]   data_adr_o,
  output logic [XLEN-1:0]   data_bus_o,
  output logic [XLEN/8-1:0] data_sel_o,
  output logic [XLEN-1:0]   data_cpu_o,
  output logic              stall_o,
  output logic              done_o,
  output logic              misaligned_o,
  output logic              bus_err_o
);

  localparam int SW = XLEN / 8;
  localparam int OW = $clog2(SW);
  localparam int CW = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;
  localparam logic [CW-1:0] LAST = CW'(WAIT_MAX - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e          state_q;
  logic [CW-1:0]   cnt_q;
  logic            rd_q, wr_q;
  logic [XLEN-1:0] adr_q, wdat_q, cpu_q;
  logic [SW-1:0]   sel_q;
  logic [2:0]      f3_q;
  logic [OW-1:0]   off_q;
  logic            done_q, mis_q, err_q;

  logic            one_req, both_req, f3_ok, mis_al;
  logic            can_acc, accept, reject;
  logic [SW-1:0]   mask;
  logic [SW-1:0]   sel_d;
  logic [XLEN-1:0] wdat_d, adr_d, lane, ld_d;

  assign one_req  = mem_read_i ^ mem_write_i;
  assign both_req = mem_read_i & mem_write_i;

  always_comb begin
    f3_ok = 1'b0;
    if (mem_read_i) begin
      case (funct3)
        3'b000, 3'b001, 3'b010,
        3'b100, 3'b101: f3_ok = 1'b1;
        3'b011, 3'b110: f3_ok = (XLEN == 64);
        default:        f3_ok = 1'b0;
      endcase
    end else begin
      case (funct3)
        3'b000, 3'b001, 3'b010: f3_ok = 1'b1;
        3'b011:                 f3_ok = (XLEN == 64);
        default:                f3_ok = 1'b0;
      endcase
    end
  end

  always_comb begin
    case (funct3[1:0])
      2'd1:    mis_al = addr_i[0];
      2'd2:    mis_al = |addr_i[1:0];
      2'd3:    mis_al = |addr_i[2:0];
      default: mis_al = 1'b0;
    endcase
  end

  assign can_acc = (state_q != BUSY);
  assign accept  = can_acc & one_req & f3_ok & ~mis_al;
  assign reject  = can_acc & (both_req | (one_req & (~f3_ok | mis_al)));
  assign stall_o = ~rst & ((state_q == BUSY) | accept);

  always_comb begin
    case (funct3[1:0])
      2'd0:    mask = SW'(1);
      2'd1:    mask = SW'(3);
      2'd2:    mask = SW'(15);
      default: mask = SW'(255);
    endcase
  end

  assign sel_d = mask << addr_i[OW-1:0];
  assign adr_d = {addr_i[XLEN-1:OW], OW'(0)};

  always_comb begin
    case (funct3[1:0])
      2'd0:    wdat_d = {SW{store_data_i[7:0]}};
      2'd1:    wdat_d = {(SW/2){store_data_i[15:0]}};
      2'd2:    wdat_d = {(SW/4){store_data_i[31:0]}};
      default: wdat_d = store_data_i;
    endcase
  end

  // Bring the addressed lane down to bit 0 before extension.
  assign lane = data_bus_i >> {off_q, 3'b000};

  always_comb begin
    case (f3_q)
      3'b000:  ld_d = XLEN'($signed(lane[7:0]));
      3'b001:  ld_d = XLEN'($signed(lane[15:0]));
      3'b010:  ld_d = XLEN'($signed(lane[31:0]));
      3'b100:  ld_d = XLEN'(lane[7:0]);
      3'b101:  ld_d = XLEN'(lane[15:0]);
      3'b110:  ld_d = XLEN'(lane[31:0]);
      default: ld_d = lane;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      adr_q   <= '0;
      wdat_q  <= '0;
      sel_q   <= '0;
      cpu_q   <= '0;
      f3_q    <= '0;
      off_q   <= '0;
      done_q  <= 1'b0;
      mis_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      mis_q  <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        BUSY: begin
          cnt_q <= cnt_q + 1'b1;
          if (data_good) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            if (rd_q) cpu_q <= ld_d;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            adr_q   <= '0;
            wdat_q  <= '0;
            sel_q   <= '0;
          end else if (WAIT_MAX != 0 && cnt_q == LAST) begin
            state_q <= DONE;
            err_q   <= 1'b1;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            adr_q   <= '0;
            wdat_q  <= '0;
            sel_q   <= '0;
          end
        end
        default: begin
          state_q <= IDLE;
          if (accept) begin
            state_q <= BUSY;
            cnt_q   <= '0;
            rd_q    <= mem_read_i;
            wr_q    <= mem_write_i;
            adr_q   <= adr_d;
            sel_q   <= sel_d;
            wdat_q  <= mem_write_i ? wdat_d : '0;
            f3_q    <= funct3;
            off_q   <= addr_i[OW-1:0];
          end else if (reject) begin
            mis_q <= 1'b1;
          end
        end
      endcase
    end
  end

  assign data_read    = rd_q;
  assign data_write   = wr_q;
  assign data_adr_o   = adr_q;
  assign data_bus_o   = wdat_q;
  assign data_sel_o   = sel_q;
  assign data_cpu_o   = cpu_q;
  assign done_o       = done_q;
  assign misaligned_o = mis_q;
  assign bus_err_o    = err_q;

endmodule

// File: tb/tb_lsu_bus_ctrl.sv
// Bench for lsu_bus_ctrl: directed literal cases plus randomized
// traffic checked every cycle against a transaction-level model.
module tb_lsu_bus_ctrl;

  localparam int WM = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read_i, mem_write_i;
  logic [2:0]  funct3;
  logic [31:0] addr_i, store_data_i, data_bus_i;
  logic        data_good;
  logic        data_read, data_write;
  logic [31:0] data_adr_o, data_bus_o, data_cpu_o;
  logic [3:0]  data_sel_o;
  logic        stall_o, done_o, misaligned_o, bus_err_o;

  lsu_bus_ctrl #(.XLEN(32), .WAIT_MAX(WM)) dut (
    .clk(clk), .rst(rst),
    .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
    .funct3(funct3), .addr_i(addr_i),
    .store_data_i(store_data_i), .data_bus_i(data_bus_i),
    .data_good(data_good),
    .data_read(data_read), .data_write(data_write),
    .data_adr_o(data_adr_o), .data_bus_o(data_bus_o),
    .data_sel_o(data_sel_o), .data_cpu_o(data_cpu_o),
    .stall_o(stall_o), .done_o(done_o),
    .misaligned_o(misaligned_o), .bus_err_o(bus_err_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int stall_cnt = 0;

  // Model of the access in flight and of the pulses due this cycle.
  bit          m_busy, m_ld, m_done, m_err, m_mis;
  int          m_cycles;
  logic [31:0] m_adr, m_wdat, m_cpu;
  logic [3:0]  m_sel;
  logic [2:0]  m_f3;
  int          m_off;

  logic        s_stall, s_rd, s_wr, s_done, s_err, s_mis;
  logic [31:0] s_adr, s_bus, s_cpu;
  logic [3:0]  s_sel;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic int size_of(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic bit legal(input logic rd, input logic wr,
                               input logic [2:0] f3, input logic [31:0] a);
    bit ok;
    if (rd == wr) return 0;
    if (rd) ok = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    else    ok = (f3 inside {3'd0, 3'd1, 3'd2});
    return ok && (a % size_of(f3) == 0);
  endfunction

  function automatic logic [31:0] repl(input logic [2:0] f3,
                                       input logic [31:0] d);
    int sz = size_of(f3);
    longint m = (64'd1 << (8 * sz)) - 1;
    longint r = 0;
    for (int i = 0; i < 4 / sz; i++)
      r = r | ((longint'(d) & m) << (8 * sz * i));
    return r[31:0];
  endfunction

  function automatic logic [31:0] ext(input logic [2:0] f3, input int off,
                                     input logic [31:0] d);
    int sz = size_of(f3);
    longint m = (64'd1 << (8 * sz)) - 1;
    longint v = (longint'(d) >> (8 * off)) & m;
    if (!f3[2] && v[8*sz-1]) v = v | ~m;
    return v[31:0];
  endfunction

  task automatic model_reset();
    m_busy = 0; m_ld = 0; m_done = 0; m_err = 0; m_mis = 0;
    m_cycles = 0; m_adr = 0; m_wdat = 0; m_cpu = 0; m_sel = 0;
    m_f3 = 0; m_off = 0;
  endtask

  task automatic model_step();
    m_done = 0; m_err = 0; m_mis = 0;
    if (m_busy) begin
      m_cycles++;
      if (data_good) begin
        m_busy = 0; m_done = 1;
        if (m_ld) m_cpu = ext(m_f3, m_off, data_bus_i);
      end else if (m_cycles == WM) begin
        m_busy = 0; m_err = 1;
      end
    end else if (legal(mem_read_i, mem_write_i, funct3, addr_i)) begin
      m_busy = 1; m_cycles = 0; m_ld = mem_read_i; m_f3 = funct3;
      m_off = addr_i % 4;
      m_adr = addr_i & ~32'd3;
      m_sel = 4'(((1 << size_of(funct3)) - 1) << m_off);
      m_wdat = mem_write_i ? repl(funct3, store_data_i) : 32'd0;
    end else if (mem_read_i || mem_write_i) begin
      m_mis = 1;
    end
  endtask

  task automatic compare();
    bit busy_exp = m_busy;
    bit st = busy_exp | legal(mem_read_i, mem_write_i, funct3, addr_i);
    s_stall = stall_o; s_rd = data_read; s_wr = data_write;
    s_done = done_o; s_err = bus_err_o; s_mis = misaligned_o;
    s_adr = data_adr_o; s_bus = data_bus_o; s_cpu = data_cpu_o;
    s_sel = data_sel_o;
    if (stall_o) stall_cnt++;
    chk("stall", stall_o, st);
    chk("data_read", data_read, busy_exp & m_ld);
    chk("data_write", data_write, busy_exp & !m_ld);
    chk("data_adr", data_adr_o, busy_exp ? m_adr : 32'd0);
    chk("data_sel", data_sel_o, busy_exp ? m_sel : 4'd0);
    chk("data_bus", data_bus_o, busy_exp ? m_wdat : 32'd0);
    chk("data_cpu", data_cpu_o, m_cpu);
    chk("done", done_o, m_done);
    chk("bus_err", bus_err_o, m_err);
    chk("misaligned", misaligned_o, m_mis);
  endtask

  task automatic cyc(input logic rd, input logic wr, input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] sd,
                     input logic [31:0] db, input logic dg);
    @(negedge clk);
    mem_read_i = rd; mem_write_i = wr; funct3 = f3; addr_i = a;
    store_data_i = sd; data_bus_i = db; data_good = dg;
    #1 compare();
    @(posedge clk);
    model_step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 3'd0, 0, 0, 0, 0);
  endtask

  logic        r_rd, r_wr;
  logic [2:0]  r_f3;
  logic [31:0] r_a, r_sd;

  initial begin
    rst = 1'b1;
    mem_read_i = 0; mem_write_i = 0; funct3 = 0; addr_i = 0;
    store_data_i = 0; data_bus_i = 0; data_good = 0;
    model_reset();
    #12;
    chk("reset_outs", {stall_o, data_read, data_write, data_adr_o,
        data_sel_o, done_o, misaligned_o, bus_err_o}, 0);
    chk("reset_cpu", data_cpu_o, 0);
    @(negedge clk); rst = 1'b0;

    // LW 0x104, data_good on second BUSY cycle
    stall_cnt = 0;
    cyc(1, 0, 3'b010, 32'h104, 0, 0, 0);
    cyc(1, 0, 3'b010, 32'h104, 0, 0, 0);
    chk("lw_adr", s_adr, 32'h104);
    chk("lw_sel", s_sel, 4'b1111);
    chk("lw_rd", s_rd, 1);
    cyc(1, 0, 3'b010, 32'h104, 0, 32'hDEADBEEF, 1);
    cyc(0, 0, 3'b000, 0, 0, 0, 0);
    chk("lw_cpu", s_cpu, 32'hDEADBEEF);
    chk("lw_done", s_done, 1);
    chk("lw_stall_cycles", stall_cnt, 3);

    // LB / LBU 0x103
    cyc(1, 0, 3'b000, 32'h103, 0, 0, 0);
    cyc(1, 0, 3'b000, 32'h103, 0, 32'h80FF0000, 1);
    chk("lb_sel", s_sel, 4'b1000);
    cyc(0, 0, 3'b000, 0, 0, 0, 0);
    chk("lb_cpu", s_cpu, 32'hFFFFFF80);
    cyc(1, 0, 3'b100, 32'h103, 0, 0, 0);
    cyc(1, 0, 3'b100, 32'h103, 0, 32'h80FF0000, 1);
    cyc(0, 0, 3'b000, 0, 0, 0, 0);
    chk("lbu_cpu", s_cpu, 32'h00000080);

    // SH 0x22
    cyc(0, 1, 3'b001, 32'h22, 32'h1234ABCD, 0, 0);
    cyc(0, 1, 3'b001, 32'h22, 32'h1234ABCD, 0, 1);
    chk("sh_wr", s_wr, 1);
    chk("sh_adr", s_adr, 32'h20);
    chk("sh_sel", s_sel, 4'b1100);
    chk("sh_bus", s_bus, 32'hABCDABCD);
    cyc(0, 0, 3'b000, 0, 0, 0, 0);
    chk("sh_done", s_done, 1);
    chk("sh_cpu_kept", s_cpu, 32'h00000080);

    // Misaligned LW and both-request
    cyc(1, 0, 3'b010, 32'h101, 0, 0, 0);
    chk("mis_stall", s_stall, 0);
    cyc(0, 0, 3'b000, 0, 0, 0, 0);
    chk("mis_pulse", s_mis, 1);
    chk("mis_rd", s_rd, 0);
    cyc(1, 1, 3'b010, 32'h100, 0, 0, 0);
    chk("both_stall", s_stall, 0);
    cyc(0, 0, 3'b000, 0, 0, 0, 0);
    chk("both_pulse", s_mis, 1);

    // Timeout after WM busy cycles
    cyc(1, 0, 3'b010, 32'h200, 0, 0, 0);
    for (int i = 0; i < WM; i++) cyc(1, 0, 3'b010, 32'h200, 0, 0, 0);
    chk("to_rd_last_busy", s_rd, 1);
    cyc(0, 0, 3'b000, 0, 0, 0, 0);
    chk("to_err", s_err, 1);
    chk("to_done", s_done, 0);
    chk("to_rd", s_rd, 0);
    chk("to_cpu", s_cpu, 32'h00000080);

    // Reset in the middle of a load
    cyc(1, 0, 3'b010, 32'h300, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_mid_outs", {stall_o, data_read, data_write, data_adr_o,
        data_sel_o, done_o, misaligned_o, bus_err_o}, 0);
    chk("rst_mid_cpu", data_cpu_o, 0);
    model_reset();
    @(negedge clk); rst = 1'b0;
    mem_read_i = 0;
    idle(2);
    cyc(1, 0, 3'b001, 32'h2, 0, 0, 0);
    cyc(1, 0, 3'b001, 32'h2, 0, 32'h7FFF0000, 1);
    cyc(0, 0, 3'b000, 0, 0, 0, 0);
    chk("lh_after_rst", s_cpu, 32'h00007FFF);

    // Random traffic; request held while the model has an access in flight
    r_rd = 0; r_wr = 0; r_f3 = 0; r_a = 0; r_sd = 0;
    for (int n = 0; n < 3000; n++) begin
      if (!m_busy) begin
        int k = $urandom_range(0, 9);
        r_rd = (k >= 3 && k <= 6) || k == 9;
        r_wr = (k >= 7);
        r_f3 = 3'($urandom_range(0, 7));
        r_a = $urandom & 32'hFFF;
        if ($urandom_range(0, 2) != 0)
          r_a = r_a & ~32'(size_of(r_f3) - 1);
        r_sd = $urandom;
      end
      cyc(r_rd, r_wr, r_f3, r_a, r_sd, $urandom,
          1'($urandom_range(0, 99) < 35));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
